// File: rtl/dark_mem_sequencer.sv
// rtl/dark_mem_sequencer.sv - single-request memory sequencer with wait states, range check and byte-lane writes
// Optional DARKMEM_RMW_EN: read-modify-write for partial writes to RAMs without byte enables.
module dark_mem_sequencer #(
    parameter int AW          = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic          CLK,
    input  logic          RES,
    input  logic          REF_VALID,
    input  logic          REF_RD,
    input  logic          REF_WR,
    input  logic [31:0]   REF_ADDR,
    input  logic [31:0]   REF_DATA,
    input  logic [3:0]    REF_BE,
    output logic          MEM_READY,
    output logic          MEM_VALID,
    output logic [31:0]   MEM_DATA,
    output logic          RAM_EN,
    output logic [3:0]    RAM_WE,
    output logic [AW-1:0] RAM_ADDR,
    output logic [31:0]   RAM_WDATA,
    input  logic [31:0]   RAM_RDATA,
    output logic          ERR
);
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CW-1:0] WS_LD = CW'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE, S_ACCESS, S_CAPTURE, S_RESP, S_REARM, S_RD_HOLD, S_MERGE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          l_rd, l_rd_n, l_oor, l_oor_n;
    logic          ready_n, valid_n, en_n, err_n;
    logic [31:0]   data_n, wdata_n;
    logic [3:0]    we_n;
    logic [AW-1:0] addr_n;

    // A write wins when both strobes are set; neither set is a null access.
    logic acc_wr, acc_rd, acc_oor;
    assign acc_wr  = REF_WR;
    assign acc_rd  = REF_RD & ~REF_WR;
    assign acc_oor = (REF_ADDR >> (AW + 2)) != 32'd0;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^REF_ADDR[1:0];

`ifdef DARKMEM_RMW_EN
    logic        l_rmw, l_rmw_n;
    logic [3:0]  l_be, l_be_n;
    logic [31:0] l_data, l_data_n;
    logic        acc_part;
    assign acc_part = acc_wr & ~acc_oor & (REF_BE != 4'h0) & (REF_BE != 4'hF);
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        l_rd_n  = l_rd;
        l_oor_n = l_oor;
        ready_n = MEM_READY;
        valid_n = MEM_VALID;
        data_n  = MEM_DATA;
        en_n    = RAM_EN;
        we_n    = RAM_WE;
        addr_n  = RAM_ADDR;
        wdata_n = RAM_WDATA;
        err_n   = ERR;
`ifdef DARKMEM_RMW_EN
        l_rmw_n  = l_rmw;
        l_be_n   = l_be;
        l_data_n = l_data;
`endif
        case (state)
            S_IDLE: begin
                if (REF_VALID) begin
                    l_rd_n  = acc_rd;
                    l_oor_n = acc_oor;
                    ready_n = 1'b0;
                    addr_n  = REF_ADDR[AW+1:2];
                    wdata_n = REF_DATA;
                    cnt_n   = WS_LD;
                    err_n   = ERR | acc_oor;
                    en_n    = (acc_wr | acc_rd) & ~acc_oor;
                    we_n    = (acc_wr & ~acc_oor) ? REF_BE : 4'h0;
                    state_n = S_ACCESS;
`ifdef DARKMEM_RMW_EN
                    l_rmw_n  = acc_part;
                    l_be_n   = REF_BE;
                    l_data_n = REF_DATA;
                    if (acc_part) begin
                        we_n    = 4'h0;
                        state_n = S_RD_HOLD;
                    end
`endif
                end
            end
            S_ACCESS: begin
                if (cnt == '0) begin
                    en_n    = 1'b0;
                    we_n    = 4'h0;
                    state_n = S_CAPTURE;
`ifdef DARKMEM_RMW_EN
                    // Merged write carries no read data, so respond straight away.
                    if (l_rmw) begin
                        valid_n = 1'b1;
                        state_n = S_RESP;
                    end
`endif
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_CAPTURE: begin
                if (l_rd) begin
                    data_n = l_oor ? 32'd0 : RAM_RDATA;
                end
                valid_n = 1'b1;
                state_n = S_RESP;
            end
            S_RESP: begin
                valid_n = 1'b0;
                state_n = S_REARM;
            end
            S_REARM: begin
                if (!REF_VALID) begin
                    ready_n = 1'b1;
                    state_n = S_IDLE;
                end
            end
`ifdef DARKMEM_RMW_EN
            S_RD_HOLD: begin
                if (cnt == '0) begin
                    en_n    = 1'b0;
                    state_n = S_MERGE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_MERGE: begin
                for (int i = 0; i < 4; i++) begin
                    wdata_n[i*8 +: 8] = l_be[i] ? l_data[i*8 +: 8] : RAM_RDATA[i*8 +: 8];
                end
                en_n    = 1'b1;
                we_n    = 4'hF;
                cnt_n   = WS_LD;
                state_n = S_ACCESS;
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state     <= S_IDLE;
            cnt       <= '0;
            l_rd      <= 1'b0;
            l_oor     <= 1'b0;
            MEM_READY <= 1'b1;
            MEM_VALID <= 1'b0;
            MEM_DATA  <= 32'd0;
            RAM_EN    <= 1'b0;
            RAM_WE    <= 4'h0;
            RAM_ADDR  <= '0;
            RAM_WDATA <= 32'd0;
            ERR       <= 1'b0;
`ifdef DARKMEM_RMW_EN
            l_rmw     <= 1'b0;
            l_be      <= 4'h0;
            l_data    <= 32'd0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            l_rd      <= l_rd_n;
            l_oor     <= l_oor_n;
            MEM_READY <= ready_n;
            MEM_VALID <= valid_n;
            MEM_DATA  <= data_n;
            RAM_EN    <= en_n;
            RAM_WE    <= we_n;
            RAM_ADDR  <= addr_n;
            RAM_WDATA <= wdata_n;
            ERR       <= err_n;
`ifdef DARKMEM_RMW_EN
            l_rmw     <= l_rmw_n;
            l_be      <= l_be_n;
            l_data    <= l_data_n;
`endif
        end
    end
endmodule

// File: tb/tb_dark_mem_sequencer.sv
// tb/tb_dark_mem_sequencer.sv - directed bench: two sequencers (0 and 3 wait states) sharing one request bus
`timescale 1ns/1ps
module tb_dark_mem_sequencer;
    localparam int AW = 12;
`ifdef DARKMEM_RMW_EN
    localparam int A_PW = 3;
    localparam int B_PW = 9;
`else
    localparam int A_PW = 2;
    localparam int B_PW = 5;
`endif

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RES, REF_VALID, REF_RD, REF_WR;
    logic [31:0] REF_ADDR, REF_DATA;
    logic [3:0]  REF_BE;

    logic          a_ready, a_valid, a_en, a_err, b_ready, b_valid, b_en, b_err;
    logic [31:0]   a_data, a_wdata, a_rdata, b_data, b_wdata, b_rdata;
    logic [3:0]    a_we, b_we;
    logic [AW-1:0] a_addr, b_addr;

    dark_mem_sequencer #(.AW(AW), .WAIT_STATES(0)) u_a (
        .CLK(CLK), .RES(RES), .REF_VALID(REF_VALID), .REF_RD(REF_RD), .REF_WR(REF_WR),
        .REF_ADDR(REF_ADDR), .REF_DATA(REF_DATA), .REF_BE(REF_BE),
        .MEM_READY(a_ready), .MEM_VALID(a_valid), .MEM_DATA(a_data),
        .RAM_EN(a_en), .RAM_WE(a_we), .RAM_ADDR(a_addr), .RAM_WDATA(a_wdata),
        .RAM_RDATA(a_rdata), .ERR(a_err));

    dark_mem_sequencer #(.AW(AW), .WAIT_STATES(3)) u_b (
        .CLK(CLK), .RES(RES), .REF_VALID(REF_VALID), .REF_RD(REF_RD), .REF_WR(REF_WR),
        .REF_ADDR(REF_ADDR), .REF_DATA(REF_DATA), .REF_BE(REF_BE),
        .MEM_READY(b_ready), .MEM_VALID(b_valid), .MEM_DATA(b_data),
        .RAM_EN(b_en), .RAM_WE(b_we), .RAM_ADDR(b_addr), .RAM_WDATA(b_wdata),
        .RAM_RDATA(b_rdata), .ERR(b_err));

    // Byte-enabled synchronous RAM models, read data held while disabled.
    logic [31:0] a_mem [0:(1<<AW)-1];
    logic [31:0] b_mem [0:(1<<AW)-1];
    always @(posedge CLK) begin
        if (a_en) begin
            for (int i = 0; i < 4; i++) if (a_we[i]) a_mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
            a_rdata <= a_mem[a_addr];
        end
        if (b_en) begin
            for (int i = 0; i < 4; i++) if (b_we[i]) b_mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
            b_rdata <= b_mem[b_addr];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    int            a_lat, b_lat, a_en_n, b_en_n, a_vld_n, b_vld_n;
    logic [31:0]   a_rd, b_rd;
    logic [AW-1:0] a_ea;
    logic          we_odd, rdy_hold, rdy_drop;

    // Present one request; keep REF_VALID high until 'hold' edges after the slower response.
    task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be, input int hold);
        @(negedge CLK);
        REF_VALID = 1'b1; REF_RD = rd; REF_WR = wr;
        REF_ADDR = addr; REF_DATA = data; REF_BE = be;
        a_lat = 0; b_lat = 0; a_en_n = 0; b_en_n = 0; a_vld_n = 0; b_vld_n = 0;
        a_rd = 32'hx; b_rd = 32'hx; a_ea = '0; we_odd = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK); #1;
            if (a_en) begin a_en_n++; a_ea = a_addr; end
            if (b_en) b_en_n++;
            if ((a_en && a_we != 4'h0 && a_we != 4'hF) || (b_en && b_we != 4'h0 && b_we != 4'hF))
                we_odd = 1'b1;
            if (a_valid) begin a_vld_n++; if (a_lat == 0) begin a_lat = k; a_rd = a_data; end end
            if (b_valid) begin b_vld_n++; if (b_lat == 0) begin b_lat = k; b_rd = b_data; end end
            if (a_lat != 0 && b_lat != 0 && k >= b_lat + hold) break;
        end
        @(negedge CLK);
        rdy_hold = a_ready | b_ready;
        REF_VALID = 1'b0;
        @(posedge CLK); #1;
        rdy_drop = a_ready & b_ready;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int vcount;
        RES = 1'b1; REF_VALID = 1'b0; REF_RD = 1'b0; REF_WR = 1'b0;
        REF_ADDR = '0; REF_DATA = '0; REF_BE = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ready", {30'd0, a_ready, b_ready}, 32'd3);
        check("rst_valid", {30'd0, a_valid, b_valid}, 32'd0);
        check("rst_ram_en", {30'd0, a_en, b_en}, 32'd0);
        check("rst_err", {30'd0, a_err, b_err}, 32'd0);
        check("rst_data", a_data | b_data, 32'd0);
        @(negedge CLK); RES = 1'b0;

        txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1);
        check("wr_lat_ws0", a_lat, 2);
        check("wr_lat_ws3", b_lat, 5);
        txn(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1);
        check("rd_lat_ws0", a_lat, 2);
        check("rd_ram_addr", a_ea, 4);
        check("rd_data_ws0", a_rd, 32'hDEADBEEF);
        check("rd_data_ws3", b_rd, 32'hDEADBEEF);
        check("rd_en_cycles_ws0", a_en_n, 1);
        check("rd_en_cycles_ws3", b_en_n, 4);
        check("rd_lat_ws3", b_lat, 5);
        check("rd_valid_width_ws3", b_vld_n, 1);
        check("rearm_not_ready", rdy_hold, 0);
        check("ready_after_drop", rdy_drop, 1);

        txn(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1);
        txn(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1);
        check("part_wr_lat_ws0", a_lat, A_PW);
        check("part_wr_lat_ws3", b_lat, B_PW);
`ifdef DARKMEM_RMW_EN
        check("rmw_we_full_only", we_odd, 0);
`endif
        txn(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 1);
        check("be0_ram_en", a_en_n, 1);
        txn(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1);
        check("part_rd_ws0", a_rd, 32'h11BB33DD);
        check("part_rd_ws3", b_rd, 32'h11BB33DD);

        txn(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, 1);
        check("null_ram_en", a_en_n + b_en_n, 0);
        check("null_lat", a_lat, 2);
        check("null_data_kept", a_rd, 32'h11BB33DD);
        txn(1'b1, 1'b1, 32'h24, 32'hCAFEF00D, 4'hF, 1);
        check("rdwr_data_kept", b_rd, 32'h11BB33DD);
        txn(1'b1, 1'b0, 32'h24, 32'h0, 4'h0, 1);
        check("rdwr_was_write", a_rd, 32'hCAFEF00D);

        txn(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 6);
        check("hold_single_access_ws0", a_en_n, 1);
        check("hold_single_valid_ws0", a_vld_n, 1);
        check("hold_single_access_ws3", b_en_n, 4);
        check("hold_single_valid_ws3", b_vld_n, 1);
        check("hold_ready_after_drop", rdy_drop, 1);

        txn(1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'h0, 1);
        check("oor_ram_en", a_en_n + b_en_n, 0);
        check("oor_data", a_rd | b_rd, 32'd0);
        check("oor_lat", a_lat, 2);
        check("oor_err", {30'd0, a_err, b_err}, 32'd3);
        txn(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1);
        check("err_sticky", {30'd0, a_err, b_err}, 32'd3);
        check("after_oor_data", a_rd, 32'hDEADBEEF);
        @(negedge CLK); RES = 1'b1;
        @(posedge CLK); #1;
        check("err_cleared_by_res", {30'd0, a_err, b_err}, 32'd0);
        @(negedge CLK); RES = 1'b0;

        @(negedge CLK);
        REF_VALID = 1'b1; REF_RD = 1'b1; REF_WR = 1'b0; REF_ADDR = 32'h10;
        @(posedge CLK); #1;
        check("abort_en_before_res", b_en, 1);
        @(negedge CLK); RES = 1'b1;
        @(posedge CLK); #1;
        check("abort_en_cleared", {30'd0, a_en, b_en}, 32'd0);
        @(negedge CLK); RES = 1'b0; REF_VALID = 1'b0;
        vcount = 0;
        repeat (8) begin
            @(posedge CLK); #1;
            if (a_valid) vcount++;
            if (b_valid) vcount++;
        end
        check("abort_no_valid", vcount, 0);
        check("abort_ready", {30'd0, a_ready, b_ready}, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
